// File: rtl/regfile_bank.sv
// regfile_bank: 32 x N register storage bank feeding the read-port muxes.
// One synchronous write port, hardwired-zero register 0, and a one-register-
// per-cycle bulk clear of registers 1..31 with busy and dropped-write flags.
module regfile_bank #(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_ena,
  input  logic [4:0]      wr_addr,
  input  logic [N-1:0]    wr_data,
  input  logic            clr_req,
  output logic            busy,
  output logic            wr_drop,
  output logic [32*N-1:0] regs_out
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         drop_q, drop_d;
  logic         idle_wr;   // accepted host write this cycle
  logic         clr_wr;    // clear sequencer zeroing reg[cnt_q] this cycle
  logic [N-1:0] wr_val;

  // Sequencer state, clear counter and drop pulse flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic; a clear request wins over a same-cycle write, and any
  // write arriving while the clear runs is discarded and flagged.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    idle_wr = 1'b0;
    clr_wr  = 1'b0;
    wr_val  = wr_data;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = 5'd1;
          drop_d  = wr_ena;
        end else if (wr_ena) begin
          idle_wr = 1'b1;
        end
      end
      CLEAR: begin
        clr_wr = 1'b1;
        wr_val = '0;
        drop_d = wr_ena;
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  assign busy    = (state_q == CLEAR);
  assign wr_drop = drop_q;

  // Register 0 has no storage; it always reads zero.
  assign regs_out[N-1:0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [N-1:0] reg_q;
      logic         reg_we;

      // Address decode: either the host write or the clear sequencer hits
      // this register; the two never occur in the same cycle.
      assign reg_we = (idle_wr && (wr_addr == 5'(gi))) ||
                      (clr_wr && (cnt_q == 5'(gi)));

      // Storage flop for register gi; output comes straight from the flop.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          reg_q <= '0;
        end else if (reg_we) begin
          reg_q <= wr_val;
        end
      end

      assign regs_out[gi*N +: N] = reg_q;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed stimulus pushes expected post-edge snapshots into
// a scoreboard queue; a monitor pops one per falling edge and compares.
module tb_regfile_bank;

  localparam int N = 32;

  logic            clk;
  logic            rst;
  logic            wr_ena;
  logic [4:0]      wr_addr;
  logic [N-1:0]    wr_data;
  logic            clr_req;
  logic            busy;
  logic            wr_drop;
  logic [32*N-1:0] regs_out;

  regfile_bank #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_drop  (wr_drop),
    .regs_out (regs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            busy;
    logic            drop;
    logic [32*N-1:0] regs;
  } exp_t;

  exp_t         sb_q[$];
  logic [N-1:0] exp_regs [32];
  int           checks = 0;
  int           errors = 0;

  function automatic logic [32*N-1:0] pack_regs();
    logic [32*N-1:0] v;
    v = '0;
    for (int k = 0; k < 32; k++) v[k*N +: N] = exp_regs[k];
    return v;
  endfunction

  task automatic push_exp(input string nm, input logic eb, input logic ed);
    exp_t e;
    e.name = nm;
    e.busy = eb;
    e.drop = ed;
    e.regs = pack_regs();
    sb_q.push_back(e);
  endtask

  // Drive one cycle of inputs, let the edge happen, then queue the expectation.
  task automatic step(input logic ena, input logic [4:0] addr, input logic [N-1:0] data,
                      input logic clr, input logic eb, input logic ed,
                      input string nm, input bit do_push = 1'b1);
    wr_ena  = ena;
    wr_addr = addr;
    wr_data = data;
    clr_req = clr;
    @(posedge clk);
    #1;
    if (do_push) push_exp(nm, eb, ed);
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      int   bad;
      e = sb_q.pop_front();
      checks++;
      if (busy !== e.busy) begin
        errors++;
        $display("FAIL %s busy got %b exp %b", e.name, busy, e.busy);
      end
      checks++;
      if (wr_drop !== e.drop) begin
        errors++;
        $display("FAIL %s wr_drop got %b exp %b", e.name, wr_drop, e.drop);
      end
      checks++;
      bad = -1;
      for (int k = 31; k >= 0; k--)
        if (regs_out[k*N +: N] !== e.regs[k*N +: N]) bad = k;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s slot %0d got %h exp %h", e.name, bad,
                 regs_out[bad*N +: N], e.regs[bad*N +: N]);
      end else begin
        $display("%s busy=%b drop=%b ok", e.name, busy, wr_drop);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) exp_regs[k] = '0;
    rst = 1'b0;

    // Reset held for two cycles.
    step(0, 5'd0, '0, 0, 0, 0, "rst_a");
    step(0, 5'd0, '0, 0, 0, 0, "rst_b");
    rst = 1'b1;
    step(0, 5'd0, '0, 0, 0, 0, "release");

    // Single write then write to register 0.
    exp_regs[5] = 32'hDEADBEEF;
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, "wr5");
    step(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, "wr0_ignored");

    // Sweep every writable address.
    for (int k = 1; k < 32; k++) begin
      exp_regs[k] = N'(k * 3 + 1);
      step(1, 5'(k), N'(k * 3 + 1), 0, 0, 0, $sformatf("sweep%0d", k));
    end
    step(0, 5'd0, '0, 0, 0, 0, "sweep_hold");

    // Clear 1: second request at cycle 5, writes at cycle 10 and the final edge.
    step(0, 5'd0, '0, 1, 1, 0, "clr1_acc");
    for (int i = 1; i < 32; i++) begin
      logic ena;
      ena = (i == 10) || (i == 31);
      exp_regs[i] = '0;
      step(ena, (i == 10) ? 5'd20 : 5'd4, (i == 10) ? 32'h1234 : 32'h5,
           (i == 5), (i < 31), ena, $sformatf("clr1_c%0d", i));
    end

    // Clear 2 accepted on the first edge after busy falls, colliding with a write.
    step(1, 5'd7, 32'd9, 1, 1, 1, "clr2_acc_coll");
    for (int i = 1; i < 32; i++)
      step(0, 5'd0, '0, 0, (i < 31), 0, $sformatf("clr2_c%0d", i));
    step(0, 5'd0, '0, 0, 0, 0, "clr2_done");

    // Reload a few slots, then clear 3 with a colliding write to slot 7.
    exp_regs[7]  = 32'h77;
    step(1, 5'd7, 32'h77, 0, 0, 0, "load7");
    exp_regs[20] = 32'h2020;
    step(1, 5'd20, 32'h2020, 0, 0, 0, "load20");
    exp_regs[31] = 32'h3131;
    step(1, 5'd31, 32'h3131, 0, 0, 0, "load31");
    step(1, 5'd7, 32'd9, 1, 1, 1, "clr3_acc_coll");
    for (int i = 1; i < 12; i++) begin
      exp_regs[i] = '0;
      step(0, 5'd0, '0, 0, 1, 0, $sformatf("clr3_c%0d", i));
    end
    exp_regs[12] = '0;
    step(0, 5'd0, '0, 0, 1, 0, "clr3_c12", 1'b0);

    // Asynchronous reset between edges during the clear.
    #1;
    rst = 1'b0;
    for (int k = 0; k < 32; k++) exp_regs[k] = '0;
    push_exp("rst_async", 0, 0);
    step(0, 5'd0, '0, 0, 0, 0, "rst_hold");
    rst = 1'b1;
    exp_regs[3] = 32'hABC;
    step(1, 5'd3, 32'hABC, 0, 0, 0, "wr3_after_rst");
    step(0, 5'd0, '0, 0, 0, 0, "final_idle");

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- 32-entry by N-bit register storage bank. It is the sequential state that directly feeds the register file's 32:1 read-port muxes.
- All 32 register values are presented in parallel on a flattened output bus; each read mux selects from that bus by address.
- Provides one synchronous write port with address decode and a hardwired-zero register 0.
- Provides a multi-cycle bulk-clear sequencer (one register per cycle) with a busy indication and a dropped-write flag.

Parameters:
- N, 32, width in bits of each register and of wr_data.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- wr_ena  input  1  write request for the current cycle.
- wr_addr  input  5  destination register index, 0..31.
- wr_data  input  N  data to write.
- clr_req  input  1  request to clear registers 1..31 to zero.
- busy  output  1  high while the clear sequence runs.
- wr_drop  output  1  one-cycle registered pulse: a write request was discarded.
- regs_out  output  32*N  flattened register contents; register k occupies bits [k*N +: N].

Behaviour:
- Reset (rst=0, asynchronous):
  - all 32 registers = 0
  - state = IDLE, clear counter = 0
  - busy = 0, wr_drop = 0
- Release of rst is synchronous to clk; the first active edge after release behaves as IDLE.
- regs_out is driven directly from the register flops. There is no write-to-output bypass: a value written at edge t appears on regs_out after edge t.
- Register 0:
  - regs_out[N-1:0] is constant 0 at all times.
  - Writes to address 0 are ignored silently. They do not pulse wr_drop.
- State machine, two states, IDLE and CLEAR:
  - IDLE, clr_req=1 at edge:
    - state <= CLEAR, counter <= 1, busy <= 1.
    - Any wr_ena in the same cycle is discarded (clear has priority) and wr_drop <= 1.
  - IDLE, clr_req=0, wr_ena=1, wr_addr!=0: reg[wr_addr] <= wr_data, wr_drop <= 0.
  - IDLE, otherwise: no register change, wr_drop <= 0.
  - CLEAR, each edge:
    - reg[counter] <= 0.
    - If counter==31: state <= IDLE, busy <= 0, counter <= 0. Otherwise counter <= counter+1.
  - CLEAR: wr_ena=1 is discarded and wr_drop <= 1 for that edge, including the final clear edge. wr_drop <= 0 otherwise.
  - CLEAR: clr_req is ignored (no restart, no extension).
- Clear timing:
  - busy is high for exactly 31 cycles, covering the edges that clear registers 1..31 in ascending order.
  - A new clr_req is accepted on the first edge after busy falls.
- wr_drop is a registered pulse, high for the cycle following each discarding edge. It is not sticky.
- Reset asserted mid-CLEAR: all registers are zeroed immediately, state returns to IDLE, busy and wr_drop go to 0. No partial sequence resumes.
- wr_addr and wr_data are don't-care when wr_ena=0. X on them then must not corrupt state.
- Registers 1..31 retain their values indefinitely absent a write, clear, or reset.

Test Plan:
- Reset then write: rst low 2 cycles, release, then wr_ena=1 with wr_addr=5, wr_data=32'hDEADBEEF for 1 cycle.
  - regs_out bits [5*32 +: 32] = 32'hDEADBEEF from the next cycle.
  - All other slots stay 0; wr_drop stays 0.
- Register 0 protection: write wr_addr=0, wr_data=32'hFFFFFFFF.
  - Slot 0 stays 0; wr_drop stays 0; all slots unchanged.
- Full sweep: write k*3+1 to every address 1..31 on consecutive cycles, then check.
  - Each slot k = k*3+1; slot 0 = 0.
  - Last-written value is visible one cycle after its edge.
- Bulk clear: with all registers loaded, pulse clr_req for 1 cycle.
  - busy is high exactly 31 cycles.
  - Slot k reads 0 starting k cycles after the accepting edge.
  - busy falls and all slots read 0 after cycle 31.
- Collisions:
  - clr_req=1 and wr_ena=1 (addr 7, data 9) in the same IDLE cycle: slot 7 is cleared, never 9, and wr_drop pulses once.
  - wr_ena on cycle 10 of CLEAR: wr_drop pulses.
  - A second clr_req during CLEAR does not extend busy beyond 31 cycles.
- Reset mid-clear: assert rst (asynchronous, between edges) at CLEAR cycle 12.
  - busy and all slots go to 0 immediately.
  - After release, a write to addr 3 succeeds on the first edge.
